// File: rtl/id_stage.sv
// rtl/id_stage.sv - instruction decode stage with register file, load-use hazard detection and ID/EX register
//
// Decodes the instruction held in IF/ID, reads the 32-entry register file with a
// write-through bypass from writeback, and detects load-use hazards against the
// instruction currently in ID/EX. All decoded results are registered into the
// ID/EX pipeline register every clock.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   ifid_pc_i, ifid_instr_i  PC and instruction of the instruction in ID
//   flush_i                  squash the instruction in ID (branch taken in EX)
//   wb_regwrite_i/rd_i/data_i  register file write port from writeback
//   pcwrite_o, ifidwrite_o   0 = hold PC / IF/ID for one stall cycle
//   idex_*_o                 ID/EX pipeline register contents
module id_stage #(
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] SP_INIT = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       ifid_pc_i,
  input  logic [31:0]       ifid_instr_i,
  input  logic              flush_i,
  input  logic              wb_regwrite_i,
  input  logic [4:0]        wb_rd_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic              pcwrite_o,
  output logic              ifidwrite_o,
  output logic [31:0]       idex_pc_o,
  output logic [DATA_W-1:0] idex_rs1_data_o,
  output logic [DATA_W-1:0] idex_rs2_data_o,
  output logic [31:0]       idex_imm_o,
  output logic [4:0]        idex_rs1_o,
  output logic [4:0]        idex_rs2_o,
  output logic [4:0]        idex_rd_o,
  output logic [2:0]        idex_funct3_o,
  output logic              idex_funct7b5_o,
  output logic              idex_regwrite_o,
  output logic              idex_memread_o,
  output logic              idex_memwrite_o,
  output logic              idex_memtoreg_o,
  output logic              idex_branch_o,
  output logic              idex_alusrc_o,
  output logic [1:0]        idex_aluop_o
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Control bundle order: regwrite, memread, memwrite, memtoreg, branch, alusrc, aluop[1:0]
  typedef struct packed {
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       branch;
    logic       alusrc;
    logic [1:0] aluop;
  } ctl_t;

  logic [DATA_W-1:0] rf_q [32];

  logic [6:0]        opcode;
  logic [4:0]        rs1, rs2, rd;
  logic [DATA_W-1:0] rs1_data, rs2_data;
  logic [31:0]       imm;
  logic              rs2_used;
  logic              stall;
  ctl_t              dec_ctl;

  ctl_t              ctl_d, ctl_q;
  logic [31:0]       pc_q, imm_q;
  logic [DATA_W-1:0] rs1_data_q, rs2_data_q;
  logic [4:0]        rs1_q, rs2_q, rd_q;
  logic [2:0]        funct3_q;
  logic              funct7b5_q;

  assign opcode = ifid_instr_i[6:0];
  assign rd     = ifid_instr_i[11:7];
  assign rs1    = ifid_instr_i[19:15];
  assign rs2    = ifid_instr_i[24:20];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= (i == 2) ? SP_INIT : '0;
      end
    end else if (wb_regwrite_i && wb_rd_i != 5'd0) begin
      rf_q[wb_rd_i] <= wb_data_i;
    end
  end

  // Writeback in the same cycle is visible to the reader without waiting for the edge.
  always_comb begin
    rs1_data = rf_q[rs1];
    rs2_data = rf_q[rs2];
    if (wb_regwrite_i && wb_rd_i != 5'd0 && wb_rd_i == rs1) rs1_data = wb_data_i;
    if (wb_regwrite_i && wb_rd_i != 5'd0 && wb_rd_i == rs2) rs2_data = wb_data_i;
    if (rs1 == 5'd0) rs1_data = '0;
    if (rs2 == 5'd0) rs2_data = '0;
  end

  always_comb begin
    dec_ctl  = '0;
    imm      = 32'd0;
    rs2_used = 1'b0;
    case (opcode)
      OP_R: begin
        dec_ctl.regwrite = 1'b1;
        dec_ctl.aluop    = 2'b10;
        rs2_used         = 1'b1;
      end
      OP_I: begin
        dec_ctl.regwrite = 1'b1;
        dec_ctl.alusrc   = 1'b1;
        dec_ctl.aluop    = 2'b11;
        imm              = {{20{ifid_instr_i[31]}}, ifid_instr_i[31:20]};
      end
      OP_LOAD: begin
        dec_ctl.regwrite = 1'b1;
        dec_ctl.memread  = 1'b1;
        dec_ctl.memtoreg = 1'b1;
        dec_ctl.alusrc   = 1'b1;
        imm              = {{20{ifid_instr_i[31]}}, ifid_instr_i[31:20]};
      end
      OP_STORE: begin
        dec_ctl.memwrite = 1'b1;
        dec_ctl.alusrc   = 1'b1;
        rs2_used         = 1'b1;
        imm              = {{20{ifid_instr_i[31]}}, ifid_instr_i[31:25], ifid_instr_i[11:7]};
      end
      OP_BRANCH: begin
        dec_ctl.branch   = 1'b1;
        dec_ctl.aluop    = 2'b01;
        rs2_used         = 1'b1;
        imm              = {{19{ifid_instr_i[31]}}, ifid_instr_i[31], ifid_instr_i[7],
                            ifid_instr_i[30:25], ifid_instr_i[11:8], 1'b0};
      end
      default: begin
        dec_ctl = '0;
      end
    endcase
  end

  // Load-use: the load in EX cannot forward in time, so hold fetch one cycle.
  assign stall = ctl_q.memread && rd_q != 5'd0 &&
                 (rd_q == rs1 || (rs2_used && rd_q == rs2));

  // A flush overrides the stall so the branch target is fetched.
  assign pcwrite_o   = !stall || flush_i;
  assign ifidwrite_o = !stall || flush_i;

  assign ctl_d = (flush_i || stall) ? '0 : dec_ctl;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctl_q      <= '0;
      pc_q       <= '0;
      imm_q      <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      funct3_q   <= '0;
      funct7b5_q <= 1'b0;
    end else begin
      ctl_q      <= ctl_d;
      pc_q       <= ifid_pc_i;
      imm_q      <= imm;
      rs1_data_q <= rs1_data;
      rs2_data_q <= rs2_data;
      rs1_q      <= rs1;
      rs2_q      <= rs2;
      rd_q       <= rd;
      funct3_q   <= ifid_instr_i[14:12];
      funct7b5_q <= ifid_instr_i[30];
    end
  end

  assign idex_pc_o       = pc_q;
  assign idex_rs1_data_o = rs1_data_q;
  assign idex_rs2_data_o = rs2_data_q;
  assign idex_imm_o      = imm_q;
  assign idex_rs1_o      = rs1_q;
  assign idex_rs2_o      = rs2_q;
  assign idex_rd_o       = rd_q;
  assign idex_funct3_o   = funct3_q;
  assign idex_funct7b5_o = funct7b5_q;
  assign idex_regwrite_o = ctl_q.regwrite;
  assign idex_memread_o  = ctl_q.memread;
  assign idex_memwrite_o = ctl_q.memwrite;
  assign idex_memtoreg_o = ctl_q.memtoreg;
  assign idex_branch_o   = ctl_q.branch;
  assign idex_alusrc_o   = ctl_q.alusrc;
  assign idex_aluop_o    = ctl_q.aluop;

endmodule
